// File: rtl/sreg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sreg_pkg                                                   |
// | Brief   : Shared types and constants for the scalar register file    |
// |           writeback path (writer side, FIFO, scoreboard).            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package sreg_pkg;

  localparam int REG_COUNT          = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef logic [4:0] reg_addr_t;

  // Writeback entry at the default data width; the top re-derives the
  // same layout for its own DATA_WIDTH and passes it to the FIFO as a type.
  typedef struct packed {
    reg_addr_t                     rd;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  // One-hot mask selecting a single architectural register.
  function automatic logic [REG_COUNT-1:0] reg_onehot(input reg_addr_t addr);
    logic [REG_COUNT-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage : sreg_pkg
`default_nettype wire

// File: rtl/sreg_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sreg_wb_fifo                                               |
// | Brief   : Small synchronous FIFO buffering long-latency writeback    |
// |           entries. Push is ignored when full, pop when empty.        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sreg_wb_fifo
  import sreg_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  ENTRY_T wdata,
  input  logic   pop,
  output ENTRY_T rdata,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ENTRY_T             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  // A full FIFO refuses pushes even if a pop happens in the same cycle.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop  && !empty;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign rdata = r_mem[r_rd_ptr];

  // Storage array: no reset needed, validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sreg_wb_fifo
`default_nettype wire

// File: rtl/sreg_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sreg_writeback                                             |
// | Brief   : Merges ALU and long-latency results onto the single        |
// |           register-file write port, tracks pending destinations.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sreg_writeback
  import sreg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LL_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid_i,
  input  logic [4:0]            alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  ll_valid_i,
  output logic                  ll_ready_o,
  input  logic [4:0]            ll_rd_i,
  input  logic [DATA_WIDTH-1:0] ll_data_i,
  input  logic                  issue_valid_i,
  input  logic [4:0]            issue_rd_i,
  input  logic [4:0]            rs1_addr_i,
  input  logic [4:0]            rs2_addr_i,
  output logic                  hazard_o,
  output logic [REG_COUNT-1:0]  pending_o,
  output logic                  regw_en_o,
  output logic [4:0]            rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [31:0]           commit_cnt_o
);

  typedef struct packed {
    reg_addr_t             rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                w_ll_wdata;
  entry_t                w_ll_head;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_ll_push;
  logic                  w_alu_sel;
  logic                  w_ll_pop;
  logic                  w_wr_sel;
  logic [4:0]            w_sel_rd;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [REG_COUNT-1:0]  w_pending_nxt;

  logic                  r_regw_en;
  logic [4:0]            r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [REG_COUNT-1:0]  r_pending;
  logic [31:0]           r_commit_cnt;

  // x0 results from the LL side complete the handshake but never occupy a slot.
  assign ll_ready_o = !w_fifo_full;
  assign w_ll_push  = ll_valid_i && ll_ready_o && (ll_rd_i != '0);
  assign w_ll_wdata = '{rd: ll_rd_i, data: ll_data_i};

  sreg_wb_fifo #(
    .DEPTH   (LL_DEPTH),
    .ENTRY_T (entry_t)
  ) u_ll_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_ll_push),
    .wdata (w_ll_wdata),
    .pop   (w_ll_pop),
    .rdata (w_ll_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Port arbitration: a nonzero-rd ALU result always wins; otherwise drain the FIFO.
  always_comb begin
    w_alu_sel  = alu_valid_i && (alu_rd_i != '0);
    w_ll_pop   = !w_alu_sel && !w_fifo_empty;
    w_wr_sel   = w_alu_sel || w_ll_pop;
    w_sel_rd   = w_alu_sel ? alu_rd_i   : w_ll_head.rd;
    w_sel_data = w_alu_sel ? alu_data_i : w_ll_head.data;
  end

  // Scoreboard next state: LL commit clears, issue sets afterwards so set wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_ll_pop) begin
      w_pending_nxt = w_pending_nxt & ~reg_onehot(w_ll_head.rd);
    end
    if (issue_valid_i && (issue_rd_i != '0)) begin
      w_pending_nxt = w_pending_nxt | reg_onehot(issue_rd_i);
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Registered write port; address/data hold their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regw_en <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      r_regw_en <= w_wr_sel;
      if (w_wr_sel) begin
        r_rd_addr <= w_sel_rd;
        r_rd_data <= w_sel_data;
      end
    end
  end

  // Pending-write scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Commit counter advances together with each write-enable pulse it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_cnt <= '0;
    end else if (w_wr_sel) begin
      r_commit_cnt <= r_commit_cnt + 32'd1;
    end
  end

  assign hazard_o     = ((rs1_addr_i != '0) && r_pending[rs1_addr_i]) ||
                        ((rs2_addr_i != '0) && r_pending[rs2_addr_i]);
  assign pending_o    = r_pending;
  assign regw_en_o    = r_regw_en;
  assign rd_addr_o    = r_rd_addr;
  assign rd_data_o    = r_rd_data;
  assign commit_cnt_o = r_commit_cnt;

endmodule : sreg_writeback
`default_nettype wire

// File: tb/tb_sreg_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_sreg_writeback                                          |
// | Brief   : Directed self-checking bench for sreg_writeback with an    |
// |           in-order queue of expected register-file writes.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_sreg_writeback;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        hazard;
  logic [31:0] pending;
  logic        regw_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] commit_cnt;

  wr_t exp_q [$];
  wr_t ll_q  [$];
  int  n_assert = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  sreg_writeback #(
    .DATA_WIDTH (32),
    .LL_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid_i   (alu_valid),
    .alu_rd_i      (alu_rd),
    .alu_data_i    (alu_data),
    .ll_valid_i    (ll_valid),
    .ll_ready_o    (ll_ready),
    .ll_rd_i       (ll_rd),
    .ll_data_i     (ll_data),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .rs1_addr_i    (rs1_addr),
    .rs2_addr_i    (rs2_addr),
    .hazard_o      (hazard),
    .pending_o     (pending),
    .regw_en_o     (regw_en),
    .rd_addr_o     (rd_addr),
    .rd_data_o     (rd_data),
    .commit_cnt_o  (commit_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ll_valid    = 1'b0;
    ll_rd       = '0;
    ll_data     = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  // Every write seen on the port must be the next entry in the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && regw_en === 1'b1) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 64'(rd_addr), 64'(e.rd));
        chk("wb_data", 64'(rd_data), 64'(e.data));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_regw_en", 64'(regw_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_ll_ready", 64'(ll_ready), 64'd1);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_hazard", 64'(hazard), 64'd0);
    chk("rst_commit", 64'(commit_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ALU only, visible one cycle later
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    exp_q.push_back('{rd: 5'd5, data: 32'h1234});
    step();
    idle();
    chk("t1_regw_en", 64'(regw_en), 64'd1);
    chk("t1_rd_addr", 64'(rd_addr), 64'd5);
    chk("t1_rd_data", 64'(rd_data), 64'h1234);
    step();
    chk("t1_regw_idle", 64'(regw_en), 64'd0);
    chk("t1_commit", 64'(commit_cnt), 64'd1);

    // 2: ALU/LL conflict, ALU first, LL next cycle and its pending bit cleared
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    idle();
    chk("t2_p7_set", 64'(pending[7]), 64'd1);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA_0003;
    ll_valid  = 1'b1; ll_rd  = 5'd7; ll_data  = 32'hBBBB_0007;
    exp_q.push_back('{rd: 5'd3, data: 32'hAAAA_0003});
    exp_q.push_back('{rd: 5'd7, data: 32'hBBBB_0007});
    step();
    idle();
    chk("t2_first_rd", 64'(rd_addr), 64'd3);
    step();
    chk("t2_second_en", 64'(regw_en), 64'd1);
    chk("t2_second_rd", 64'(rd_addr), 64'd7);
    step();
    chk("t2_p7_clear", 64'(pending[7]), 64'd0);
    chk("t2_commit", 64'(commit_cnt), 64'd3);

    // 3: ALU holds the port while the FIFO fills; then LL drains in order
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready_fill", 64'(ll_ready), 64'd1);
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100 + 32'(i);
      ll_valid  = 1'b1; ll_rd  = 5'(10 + i); ll_data = 32'h200 + 32'(i);
      exp_q.push_back('{rd: 5'd1, data: 32'h100 + 32'(i)});
      ll_q.push_back('{rd: 5'(10 + i), data: 32'h200 + 32'(i)});
      step();
    end
    chk("t3_ready_full", 64'(ll_ready), 64'd0);
    alu_data = 32'h104; ll_rd = 5'd20; ll_data = 32'h2FF;
    exp_q.push_back('{rd: 5'd1, data: 32'h104});
    step();
    chk("t3_ready_still_full", 64'(ll_ready), 64'd0);
    idle();
    while (ll_q.size() != 0) exp_q.push_back(ll_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_drain_en", 64'(regw_en), 64'd1);
      chk("t3_drain_rd", 64'(rd_addr), 64'(10 + i));
    end
    step();
    chk("t3_idle_en", 64'(regw_en), 64'd0);
    chk("t3_ready_back", 64'(ll_ready), 64'd1);

    // 4: scoreboard set, hazard decode, clear on LL commit, set-wins collision
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    idle();
    chk("t4_p9_set", 64'(pending[9]), 64'd1);
    rs1_addr = 5'd9; rs2_addr = 5'd0; #1;
    chk("t4_hazard_rs1", 64'(hazard), 64'd1);
    rs1_addr = 5'd0; #1;
    chk("t4_hazard_none", 64'(hazard), 64'd0);
    rs2_addr = 5'd9; #1;
    chk("t4_hazard_rs2", 64'(hazard), 64'd1);
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9999;
    exp_q.push_back('{rd: 5'd9, data: 32'h9999});
    step();
    idle();
    step();
    chk("t4_ll_rd", 64'(rd_addr), 64'd9);
    chk("t4_p9_clear", 64'(pending[9]), 64'd0);
    chk("t4_hazard_clear", 64'(hazard), 64'd0);
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9A9A;
    exp_q.push_back('{rd: 5'd9, data: 32'h9A9A});
    step();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    idle();
    chk("t4_set_wins", 64'(pending[9]), 64'd1);
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9B9B;
    exp_q.push_back('{rd: 5'd9, data: 32'h9B9B});
    step();
    idle();
    step();
    chk("t4_p9_clear2", 64'(pending[9]), 64'd0);
    rs2_addr = 5'd0;

    // 5: x0 destinations never reach the port or the scoreboard
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555;
    ll_valid  = 1'b1; ll_rd  = 5'd0; ll_data  = 32'h6666;
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    idle();
    step();
    chk("t5_no_write", 64'(regw_en), 64'd0);
    chk("t5_commit", 64'(commit_cnt), 64'd15);
    chk("t5_pending", 64'(pending), 64'd0);
    chk("t5_ready", 64'(ll_ready), 64'd1);

    // 6: asynchronous reset with FIFO occupied and a pending bit set
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h300 + 32'(i);
      ll_valid  = 1'b1; ll_rd  = 5'(20 + i); ll_data = 32'h400 + 32'(i);
      issue_valid = (i == 0); issue_rd = 5'd4;
      exp_q.push_back('{rd: 5'd2, data: 32'h300 + 32'(i)});
      step();
    end
    chk("t6_p4_set", 64'(pending[4]), 64'd1);
    #6;
    chk("t6_queue_drained", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b0;
    idle();
    rs1_addr = 5'd4;
    #1;
    chk("t6_rst_regw_en", 64'(regw_en), 64'd0);
    chk("t6_rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("t6_rst_rd_data", 64'(rd_data), 64'd0);
    chk("t6_rst_pending", 64'(pending), 64'd0);
    chk("t6_rst_hazard", 64'(hazard), 64'd0);
    chk("t6_rst_commit", 64'(commit_cnt), 64'd0);
    chk("t6_rst_ready", 64'(ll_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    chk("t6_no_stale_write", 64'(regw_en), 64'd0);
    chk("t6_commit_after", 64'(commit_cnt), 64'd0);
    rs1_addr = 5'd0;

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_sreg_writeback
`default_nettype wire
